// File: rtl/fcpu_pkg.sv
// Shared CPU definitions: datapath widths, memory/IO opcodes and request types used by the
// memory functional unit, its committer and the memory/IO back end.
package fcpu_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned RSV_ID_W    = 4;
  localparam int unsigned INSTR_W     = 6;
  localparam int unsigned DRAM_ADDR_W = 16;

  // Memory and I/O opcodes; B/R/F variants differ only in how the MFU forms the address.
  localparam logic [INSTR_W-1:0] OP_LOAD    = 6'h10;
  localparam logic [INSTR_W-1:0] OP_LOADB   = 6'h11;
  localparam logic [INSTR_W-1:0] OP_LOADR   = 6'h12;
  localparam logic [INSTR_W-1:0] OP_LOADF   = 6'h13;
  localparam logic [INSTR_W-1:0] OP_LOADBF  = 6'h14;
  localparam logic [INSTR_W-1:0] OP_LOADRF  = 6'h15;
  localparam logic [INSTR_W-1:0] OP_STORE   = 6'h18;
  localparam logic [INSTR_W-1:0] OP_STOREB  = 6'h19;
  localparam logic [INSTR_W-1:0] OP_STORER  = 6'h1A;
  localparam logic [INSTR_W-1:0] OP_STOREF  = 6'h1B;
  localparam logic [INSTR_W-1:0] OP_STOREBF = 6'h1C;
  localparam logic [INSTR_W-1:0] OP_STORERF = 6'h1D;
  localparam logic [INSTR_W-1:0] OP_INPUT   = 6'h20;
  localparam logic [INSTR_W-1:0] OP_INPUTF  = 6'h21;
  localparam logic [INSTR_W-1:0] OP_OUTPUT  = 6'h22;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [INSTR_W-1:0]  opcode;
    logic [DATA_W-1:0]   address;
    logic [DATA_W-1:0]   data;
  } mem_req_t;

  typedef enum logic [2:0] {
    MIO_IDLE = 3'd0,
    MIO_RD   = 3'd1,
    MIO_IN   = 3'd2,
    MIO_OUT  = 3'd3,
    MIO_RESP = 3'd4
  } mio_state_t;

  function automatic logic is_load(input logic [INSTR_W-1:0] op);
    return op inside {OP_LOAD, OP_LOADB, OP_LOADR, OP_LOADF, OP_LOADBF, OP_LOADRF};
  endfunction

  function automatic logic is_store(input logic [INSTR_W-1:0] op);
    return op inside {OP_STORE, OP_STOREB, OP_STORER, OP_STOREF, OP_STOREBF, OP_STORERF};
  endfunction

  function automatic logic is_input(input logic [INSTR_W-1:0] op);
    return op inside {OP_INPUT, OP_INPUTF};
  endfunction

  function automatic logic is_output(input logic [INSTR_W-1:0] op);
    return op == OP_OUTPUT;
  endfunction

endpackage

// File: rtl/mem_io_port.sv
// Memory/IO back end of the MFU: executes committed requests one at a time against the
// synchronous data RAM or the byte-wide I/O channels, returning tagged load/input results.
module mem_io_port
  import fcpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_valid,
  input  logic [RSV_ID_W-1:0]    i_rsv_id,
  input  logic [INSTR_W-1:0]     i_opcode,
  input  logic [DATA_W-1:0]      i_address,
  input  logic [DATA_W-1:0]      i_data,
  output logic                   i_ready,
  output logic                   r_valid,
  output logic [RSV_ID_W-1:0]    r_rsv_id,
  output logic [DATA_W-1:0]      r_data,
  input  logic                   r_ready,
  output logic [DRAM_ADDR_W-1:0] dram_addr,
  output logic                   dram_we,
  output logic [DATA_W-1:0]      dram_wdata,
  input  logic [DATA_W-1:0]      dram_rdata,
  output logic [7:0]             io_o_data,
  output logic                   io_o_valid,
  input  logic                   io_o_ready,
  input  logic [7:0]             io_i_data,
  input  logic                   io_i_valid,
  output logic                   io_i_ready,
  output logic                   err
);

  mio_state_t          state_q, state_d;
  logic [RSV_ID_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          obyte_q, obyte_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                word_q, word_d;
  logic                err_q, err_d;

  mem_req_t req;
  logic     accept;
  logic     unused_addr_hi;

  assign req = '{rsv_id: i_rsv_id, opcode: i_opcode, address: i_address, data: i_data};
  // Only the low word-address bits reach the RAM.
  assign unused_addr_hi = ^req.address[DATA_W-1:DRAM_ADDR_W];

  // Gated by nrst so the combinational RAM strobes stay quiet while reset is held.
  assign i_ready = nrst && (state_q == MIO_IDLE);
  assign accept  = i_valid && i_ready;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    rdata_d    = rdata_q;
    obyte_d    = obyte_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    err_d      = err_q;
    dram_addr  = '0;
    dram_we    = 1'b0;
    dram_wdata = '0;

    unique case (state_q)
      MIO_IDLE: begin
        if (accept) begin
          if (is_store(req.opcode)) begin
            dram_we    = 1'b1;
            dram_addr  = req.address[DRAM_ADDR_W-1:0];
            dram_wdata = req.data;
          end else if (is_load(req.opcode)) begin
            dram_addr = req.address[DRAM_ADDR_W-1:0];
            tag_d     = req.rsv_id;
            state_d   = MIO_RD;
          end else if (is_output(req.opcode)) begin
            obyte_d = req.data[7:0];
            state_d = MIO_OUT;
          end else if (is_input(req.opcode)) begin
            tag_d   = req.rsv_id;
            cnt_d   = 2'd0;
            word_d  = (req.opcode == OP_INPUTF);
            state_d = MIO_IN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MIO_RD: begin
        rdata_d = dram_rdata;
        state_d = MIO_RESP;
      end
      MIO_IN: begin
        if (io_i_valid) begin
          if (word_q) begin
            // Word input arrives MSB first; four shifts flush any stale data.
            rdata_d = {rdata_q[DATA_W-9:0], io_i_data};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_d = MIO_RESP;
            end
          end else begin
            rdata_d = {{(DATA_W-8){1'b0}}, io_i_data};
            state_d = MIO_RESP;
          end
        end
      end
      MIO_OUT: begin
        if (io_o_ready) begin
          state_d = MIO_IDLE;
        end
      end
      MIO_RESP: begin
        if (r_ready) begin
          state_d = MIO_IDLE;
        end
      end
      default: state_d = MIO_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= MIO_IDLE;
      tag_q   <= '0;
      rdata_q <= '0;
      obyte_q <= '0;
      cnt_q   <= '0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
      obyte_q <= obyte_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign r_valid    = (state_q == MIO_RESP);
  assign r_rsv_id   = tag_q;
  assign r_data     = rdata_q;
  assign io_o_valid = (state_q == MIO_OUT);
  assign io_o_data  = obyte_q;
  assign io_i_ready = (state_q == MIO_IN);
  assign err        = err_q;

endmodule

// File: tb/tb_mem_io_port.sv
// Directed bench for mem_io_port with a small synchronous RAM model and I/O stimulus.
module tb_mem_io_port;
  import fcpu_pkg::*;

  logic                   clk;
  logic                   nrst;
  logic                   i_valid;
  logic [RSV_ID_W-1:0]    i_rsv_id;
  logic [INSTR_W-1:0]     i_opcode;
  logic [DATA_W-1:0]      i_address;
  logic [DATA_W-1:0]      i_data;
  logic                   i_ready;
  logic                   r_valid;
  logic [RSV_ID_W-1:0]    r_rsv_id;
  logic [DATA_W-1:0]      r_data;
  logic                   r_ready;
  logic [DRAM_ADDR_W-1:0] dram_addr;
  logic                   dram_we;
  logic [DATA_W-1:0]      dram_wdata;
  logic [DATA_W-1:0]      dram_rdata;
  logic [7:0]             io_o_data;
  logic                   io_o_valid;
  logic                   io_o_ready;
  logic [7:0]             io_i_data;
  logic                   io_i_valid;
  logic                   io_i_ready;
  logic                   err;

  int vectors    = 0;
  int miscompares = 0;
  int out_xfers  = 0;

  logic [DATA_W-1:0] mem [0:255];

  mem_io_port dut (
    .clk        (clk),
    .nrst       (nrst),
    .i_valid    (i_valid),
    .i_rsv_id   (i_rsv_id),
    .i_opcode   (i_opcode),
    .i_address  (i_address),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .r_valid    (r_valid),
    .r_rsv_id   (r_rsv_id),
    .r_data     (r_data),
    .r_ready    (r_ready),
    .dram_addr  (dram_addr),
    .dram_we    (dram_we),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .io_o_data  (io_o_data),
    .io_o_valid (io_o_valid),
    .io_o_ready (io_o_ready),
    .io_i_data  (io_i_data),
    .io_i_valid (io_i_valid),
    .io_i_ready (io_i_ready),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (dram_we) mem[dram_addr[7:0]] <= dram_wdata;
    dram_rdata <= mem[dram_addr[7:0]];
  end

  always @(posedge clk) begin
    if (io_o_valid && io_o_ready) out_xfers <= out_xfers + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] id,
                     input logic [31:0] addr, input logic [31:0] data);
    i_valid   = 1'b1;
    i_opcode  = op;
    i_rsv_id  = id;
    i_address = addr;
    i_data    = data;
  endtask

  task automatic idle_req();
    i_valid   = 1'b0;
    i_opcode  = '0;
    i_rsv_id  = '0;
    i_address = '0;
    i_data    = '0;
  endtask

  task automatic in_byte(input logic [7:0] b);
    io_i_valid = 1'b0;
    step();
    io_i_valid = 1'b1;
    io_i_data  = b;
    step();
    io_i_valid = 1'b0;
  endtask

  initial begin
    nrst = 1'b1;
    r_ready = 1'b0;
    io_o_ready = 1'b0;
    io_i_valid = 1'b0;
    io_i_data = '0;
    idle_req();
    #2 nrst = 1'b0;

    // Reset: a store presented under reset must not reach the RAM.
    req(OP_STORE, 4'd1, 32'h10, 32'h1111_1111);
    #1;
    chk("rst_i_ready", i_ready, 0);
    chk("rst_dram_we", dram_we, 0);
    chk("rst_dram_addr", dram_addr, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_err", err, 0);
    idle_req();
    @(negedge clk);
    nrst = 1'b1;
    step();
    chk("idle_i_ready", i_ready, 1);

    // Store with upper address bits set, then load back.
    req(OP_STORE, 4'd0, 32'hABCD_0010, 32'hDEAD_BEEF);
    #1;
    chk("st_we", dram_we, 1);
    chk("st_addr", dram_addr, 32'h0010);
    chk("st_wdata", dram_wdata, 32'hDEAD_BEEF);
    step();
    req(OP_LOAD, 4'd3, 32'h10, 32'h0);
    #1;
    chk("ld_we", dram_we, 0);
    chk("ld_addr", dram_addr, 32'h0010);
    step();
    idle_req();
    chk("ld_rd_r_valid", r_valid, 0);
    chk("ld_rd_i_ready", i_ready, 0);
    step();
    chk("ld_r_valid", r_valid, 1);
    chk("ld_r_rsv_id", r_rsv_id, 3);
    chk("ld_r_data", r_data, 32'hDEAD_BEEF);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk("ld_done_r_valid", r_valid, 0);
    chk("ld_done_i_ready", i_ready, 1);

    // Load with result back-pressure while another store waits.
    req(OP_STOREF, 4'd0, 32'h20, 32'h1234_5678);
    step();
    req(OP_LOADR, 4'd5, 32'h20, 32'h0);
    step();
    req(OP_STORE, 4'd0, 32'h20, 32'hFFFF_FFFF);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_r_valid", r_valid, 1);
      chk("bp_r_data", r_data, 32'h1234_5678);
      chk("bp_r_rsv_id", r_rsv_id, 5);
      chk("bp_i_ready", i_ready, 0);
      chk("bp_dram_we", dram_we, 0);
      step();
    end
    r_ready = 1'b1;
    #1;
    chk("bp_hs_i_ready", i_ready, 0);
    idle_req();
    step();
    r_ready = 1'b0;
    chk("bp_idle_i_ready", i_ready, 1);
    chk("bp_mem_kept", mem[8'h20], 32'h1234_5678);

    // Output with consumer stalls.
    req(OP_OUTPUT, 4'd0, 32'h0, 32'h0000_0141);
    step();
    idle_req();
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", io_o_valid, 1);
      chk("out_data", io_o_data, 8'h41);
      step();
    end
    io_o_ready = 1'b1;
    step();
    io_o_ready = 1'b0;
    chk("out_done_valid", io_o_valid, 0);
    chk("out_xfers", out_xfers, 1);
    chk("out_i_ready", i_ready, 1);

    // Word input assembled MSB first with gaps.
    req(OP_INPUTF, 4'd2, 32'h0, 32'h0);
    step();
    idle_req();
    chk("inf_io_i_ready", io_i_ready, 1);
    in_byte(8'h3F);
    in_byte(8'h80);
    in_byte(8'h00);
    chk("inf_partial_r_valid", r_valid, 0);
    in_byte(8'h00);
    chk("inf_r_valid", r_valid, 1);
    chk("inf_r_data", r_data, 32'h3F80_0000);
    chk("inf_r_rsv_id", r_rsv_id, 2);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;

    // Single byte input is zero-extended.
    req(OP_INPUT, 4'd7, 32'h0, 32'h0);
    step();
    idle_req();
    in_byte(8'hA5);
    chk("in_r_data", r_data, 32'h0000_00A5);
    chk("in_r_rsv_id", r_rsv_id, 7);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;

    // Reset in the middle of a word input.
    req(OP_INPUTF, 4'd4, 32'h0, 32'h0);
    step();
    idle_req();
    in_byte(8'h11);
    in_byte(8'h22);
    nrst = 1'b0;
    #1;
    chk("mid_rst_io_i_ready", io_i_ready, 0);
    chk("mid_rst_r_data", r_data, 0);
    chk("mid_rst_r_rsv_id", r_rsv_id, 0);
    chk("mid_rst_i_ready", i_ready, 0);
    @(negedge clk);
    nrst = 1'b1;
    step();
    chk("post_rst_i_ready", i_ready, 1);
    req(OP_INPUT, 4'd9, 32'h0, 32'h0);
    step();
    idle_req();
    in_byte(8'h5C);
    chk("post_rst_r_data", r_data, 32'h0000_005C);
    chk("post_rst_r_rsv_id", r_rsv_id, 9);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;

    // Unsupported opcode is swallowed and flags err.
    req(6'h3F, 4'd6, 32'h0000_0030, 32'hCAFE_F00D);
    #1;
    chk("bad_i_ready", i_ready, 1);
    chk("bad_dram_we", dram_we, 0);
    chk("bad_dram_addr", dram_addr, 0);
    step();
    idle_req();
    for (int i = 0; i < 3; i++) begin
      chk("bad_err", err, 1);
      chk("bad_r_valid", r_valid, 0);
      chk("bad_io_o_valid", io_o_valid, 0);
      chk("bad_io_i_ready", io_i_ready, 0);
      chk("bad_idle", i_ready, 1);
      step();
    end
    chk("bad_out_xfers", out_xfers, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_io_port.md
Name: mem_io_port

Overview:
- Back end of the memory functional unit. Takes the MFU's committed memory/IO request stream (rsv_id, opcode, address, data) and carries out each request against the synchronous data RAM or the byte-wide I/O channels.
- Loads and inputs produce a result tagged with rsv_id, which the MFU returns on the CDB. Stores and outputs are fire-and-forget, because they are issued only after ROB commit.
- Processes one request at a time, in order.

Parameters:
- DATA_W, 32, datapath width (from fcpu_pkg)
- RSV_ID_W, 4, ROB/reservation tag width (from fcpu_pkg)
- INSTR_W, 6, opcode width (from fcpu_pkg)
- DRAM_ADDR_W, 16, data RAM word-address width

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- i_valid  in  1  request valid from MFU
- i_rsv_id  in  RSV_ID_W  request tag
- i_opcode  in  INSTR_W  request opcode
- i_address  in  DATA_W  effective word address
- i_data  in  DATA_W  store/output data
- i_ready  out  1  request accept
- r_valid  out  1  load/input result valid
- r_rsv_id  out  RSV_ID_W  result tag
- r_data  out  DATA_W  result data
- r_ready  in  1  result accept
- dram_addr  out  DRAM_ADDR_W  data RAM address
- dram_we  out  1  data RAM write enable
- dram_wdata  out  DATA_W  data RAM write data
- dram_rdata  in  DATA_W  data RAM read data, valid 1 cycle after the address
- io_o_data  out  8  output byte
- io_o_valid  out  1  output byte valid
- io_o_ready  in  1  output byte accept
- io_i_data  in  8  input byte
- io_i_valid  in  1  input byte valid
- io_i_ready  out  1  input byte accept
- err  out  1  sticky: unsupported opcode seen

Behaviour:
- Clock is clk; reset is nrst, asynchronous and active-low. While nrst=0 every output is 0 and the FSM is in IDLE; any partial INPUTF assembly and any pending result are discarded. The RAM contents are not affected.
- A request transfers when i_valid&&i_ready. i_ready=1 only in IDLE.
- FSM states: IDLE, RD, IN, OUT, RESP.
- IDLE, request is STORE/STOREB/STORER/STOREF/STOREBF/STORERF:
  - dram_we=1, dram_addr=i_address[DRAM_ADDR_W-1:0], dram_wdata=i_data, all combinationally in the accept cycle.
  - Stay in IDLE; no result. Upper address bits are ignored.
- IDLE, request is LOAD/LOADB/LOADR/LOADF/LOADBF/LOADRF:
  - Drive dram_addr in the accept cycle, latch the tag, go to RD.
  - RD: capture dram_rdata into r_data and go to RESP.
  - Load-to-r_valid latency is 2 cycles.
- IDLE, request is OUTPUT: latch i_data[7:0], go to OUT.
  - OUT: io_o_valid=1 with io_o_data stable until io_o_ready; then return to IDLE.
- IDLE, request is INPUT or INPUTF: latch the tag, clear the byte counter, go to IN.
  - IN: io_i_ready=1.
  - INPUT: the first accepted byte is zero-extended into r_data; go to RESP.
  - INPUTF: four bytes are shifted in MSB-first (r_data = {r_data[23:0], byte}). A 2-bit counter counts the bytes; after the 4th byte go to RESP.
  - IN may wait indefinitely.
- RESP: r_valid=1 with r_rsv_id/r_data held stable until r_ready. The handshake cycle returns to IDLE; i_ready is not asserted in that same cycle.
- Any other opcode: accepted and dropped, and err is set until reset.
- dram_we is never asserted outside the IDLE accept cycle of a store.
- A new request is never accepted while a result is pending, so results are in request order.

Decomposition:
- New package entries in fcpu_pkg:
  - DRAM_ADDR_W constant.
  - mem_req_t struct {rsv_id, opcode, address, data}.
  - mio_state_t enum for the FSM states.
  - Opcode-class functions is_load(), is_store(), is_input(), shared with the committer and MFU decode.
- No sub-module. The 4-byte input assembler is a counter plus shift register inside this block.

Test Plan:
- STORE addr=0x0010 data=0xDEADBEEF, then LOAD addr=0x10 tag=3 -> write seen with dram_we=1 in the accept cycle; 2 cycles after the load is accepted, r_valid=1, r_rsv_id=3, r_data=0xDEADBEEF.
- LOAD tag=5 with r_ready held 0 for 4 cycles -> r_valid and r_data stable for all 4 cycles; i_ready=0 throughout; IDLE reached after r_ready.
- OUTPUT data=0x00000141 with io_o_ready low for 3 cycles -> io_o_valid=1 and io_o_data=0x41 held for 3 cycles; exactly one byte transferred.
- INPUTF tag=2 with bytes 0x3F,0x80,0x00,0x00 and gaps between them -> r_data=0x3F800000, r_rsv_id=2. INPUT of 0xA5 -> r_data=0x000000A5.
- Assert nrst=0 midway through an INPUTF after 2 bytes -> all outputs 0 immediately; after release, i_ready=1 and the next INPUT returns only the new byte.
- Unsupported opcode -> accepted, err=1 held, no RAM or I/O activity, no result.
